// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared encodings and latency defaults for the HI/LO unit
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // Larger of two latencies, used to size the shared countdown
  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/mult_div_unit_md_arith.sv
// rtl/mult_div_unit_md_arith.sv - combinational product/quotient generation for HI/LO
module md_arith
  import mult_div_unit_pkg::*;
(
  input  md_op_e      md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0] prod;

  // Select product or quotient/remainder; the signed overflow case is pinned explicitly
  always_comb begin
    prod     = 64'd0;
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    div_zero = 1'b0;
    case (md_op)
      MD_MULT: begin
        prod   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      MD_MULTU: begin
        prod   = {32'd0, a} * {32'd0, b};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      MD_DIV: begin
        if (b == 32'd0) begin
          div_zero = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          res_lo = 32'h8000_0000;
          res_hi = 32'd0;
        end else begin
          res_lo = $signed(a) / $signed(b);
          res_hi = $signed(a) % $signed(b);
        end
      end
      MD_DIVU: begin
        if (b == 32'd0) begin
          div_zero = 1'b1;
        end else begin
          res_lo = a / b;
          res_hi = a % b;
        end
      end
      default: begin
        div_zero = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - E-stage HI/LO responder with fixed-latency commit and busy
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

  md_op_e      op;
  state_e      state;
  logic [CW-1:0] counter;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_dz;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_dz;

  assign op = md_op_e'(md_op);

  md_arith u_arith (
    .md_op    (op),
    .a        (a),
    .b        (b),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (res_dz)
  );

  // Accept in IDLE, count down in RUN, commit pending HI/LO on the last RUN edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      counter <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_dz <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              MD_MULT, MD_MULTU: begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_dz <= 1'b0;
                counter <= CW'(MULT_CYCLES);
                state   <= ST_RUN;
                busy    <= 1'b1;
              end
              MD_DIV, MD_DIVU: begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_dz <= res_dz;
                counter <= CW'(DIV_CYCLES);
                state   <= ST_RUN;
                busy    <= 1'b1;
              end
              MD_MTHI: hi <= a;
              MD_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          // Requests during RUN are dropped: the hazard unit should never send them
          counter <= counter - CW'(1);
          if (counter == CW'(1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (!pend_dz) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit with random and directed ops
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Architectural effect of one accepted op, from plain integer arithmetic
  function automatic void ref_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                 inout logic [31:0] h, inout logic [31:0] l);
    longint sx;
    longint sy;
    longint q;
    longint r;
    logic [63:0] pu;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      3'd1: begin q = sx * sy; h = q[63:32]; l = q[31:0]; end
      3'd2: begin pu = {32'd0, x} * {32'd0, y}; h = pu[63:32]; l = pu[31:0]; end
      3'd3: if (y != 0) begin q = sx / sy; r = sx % sy; l = q[31:0]; h = r[31:0]; end
      3'd4: if (y != 0) begin l = x / y; h = x % y; end
      3'd5: h = x;
      3'd6: l = x;
      default: ;
    endcase
  endfunction

  // Drive one request for a cycle; ignored=1 means the bench is deliberately violating protocol
  task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb, input bit ignored);
    logic [31:0] h0;
    logic [31:0] l0;
    exp_t e;
    h0 = hi;
    l0 = lo;
    start = 1'b1;
    md_op = op;
    a = va;
    b = vb;
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd0;
    a = $urandom;
    b = $urandom;
    if (ignored) begin
      chk("ignored_hi", hi, h0);
      chk("ignored_lo", lo, l0);
      chk("ignored_busy", {31'd0, busy}, 32'd1);
    end else if (op >= 3'd1 && op <= 3'd4) begin
      ref_op(op, va, vb, m_hi, m_lo);
      e.hi = m_hi;
      e.lo = m_lo;
      e.n  = (op <= 3'd2) ? MC : DC;
      sb.push_back(e);
    end else begin
      ref_op(op, va, vb, m_hi, m_lo);
      chk("imm_hi", hi, m_hi);
      chk("imm_lo", lo, m_lo);
      chk("imm_busy", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: on each busy fall, pop the oldest expectation and compare result and duration
  initial begin : monitor
    bit   prev;
    int   cnt;
    exp_t e;
    prev = 1'b0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev = 1'b0;
        cnt  = 0;
      end else begin
        if (busy) begin
          cnt++;
        end else if (prev) begin
          if (sb.size() == 0) begin
            chk("unexpected_commit", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("commit_hi", hi, e.hi);
            chk("commit_lo", lo, e.lo);
            chk("busy_len", cnt, e.n);
          end
          cnt = 0;
        end
        prev = busy;
      end
    end
  end

  initial begin : stim
    logic [2:0]  op;
    logic [31:0] va;
    logic [31:0] vb;
    total = 0;
    bad   = 0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    reset = 1'b0;
    start = 1'b0;
    md_op = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle();
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_idle();
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle();
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle();
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0000_0000);

    issue(3'd5, 32'h11, 32'd0, 1'b0);
    issue(3'd6, 32'h22, 32'd0, 1'b0);
    issue(3'd4, 32'd100, 32'd0, 1'b0);
    wait_idle();
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);

    issue(3'd1, 32'd7, 32'd9, 1'b0);
    issue(3'd6, 32'hAB, 32'd0, 1'b1);
    wait_idle();

    issue(3'd1, 32'd2, 32'd3, 1'b0);
    wait_idle();
    chk("b2b_mult_lo", lo, 32'd6);
    issue(3'd4, 32'd9, 32'd4, 1'b0);
    wait_idle();
    chk("b2b_div_lo", lo, 32'd2);
    chk("b2b_div_hi", hi, 32'd1);

    issue(3'd1, 32'd5, 32'd5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    void'(sb.pop_back());
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_nocommit_hi", hi, 32'd0);
    chk("abort_nocommit_lo", lo, 32'd0);
    chk("abort_nocommit_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      va = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      case ($urandom_range(0, 4))
        0: vb = 32'd0;
        1: vb = 32'($urandom_range(1, 9));
        2: vb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: vb = $urandom;
      endcase
      issue(op, va, vb, 1'b0);
      wait_idle();
    end

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    chk("final_hi", hi, m_hi);
    chk("final_lo", lo, m_lo);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
